miner_job_ctrl: RTL and testbench

Host-side job controller for the nonce-search miner. It receives a job as a byte stream (12 block bytes plus a 16-bit target) and drives the miner's block/target/start inputs. It sequences the miner's active-low reset and start, then waits for `finish` or a cycle timeout. It returns a 5-byte result frame (status plus 4 nonce bytes) on an output byte stream.

---
 rtl/miner_job_ctrl_if.sv | 39 +++
 rtl/miner_job_ctrl.sv | 173 +++++++++++++++++
 tb/tb_miner_job_ctrl.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/miner_job_ctrl_if.sv
// ============================================================================
// miner_job_ctrl_if : job/result byte streams and miner control bundle
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

interface miner_job_ctrl_if;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  block0, block1, block2, block3, block4, block5;
  logic [7:0]  block6, block7, block8, block9, block10, block11;
  logic [15:0] target;
  logic        start;
  logic        miner_rst_n;
  logic        finish;
  logic [7:0]  nonce0, nonce1, nonce2, nonce3;
  logic        busy;

  // master: host / miner side, slave: the job controller
  modport master (
    output in_data, in_valid, out_ready, finish, nonce0, nonce1, nonce2, nonce3,
    input  in_ready, out_data, out_valid, target, start, miner_rst_n, busy,
    input  block0, block1, block2, block3, block4, block5,
    input  block6, block7, block8, block9, block10, block11
  );

  modport slave (
    input  in_data, in_valid, out_ready, finish, nonce0, nonce1, nonce2, nonce3,
    output in_ready, out_data, out_valid, target, start, miner_rst_n, busy,
    output block0, block1, block2, block3, block4, block5,
    output block6, block7, block8, block9, block10, block11
  );
endinterface

`default_nettype wire

// File: rtl/miner_job_ctrl.sv
// ============================================================================
// miner_job_ctrl : loads a job byte stream, sequences the miner, returns a
//                  5-byte status/nonce frame.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module miner_job_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 2000000,
  parameter int unsigned RST_CYCLES     = 2
) (
  input  logic             clk,
  input  logic             reset,
  miner_job_ctrl_if.slave  bus
);

  localparam logic [31:0] C_T_LAST = 32'(TIMEOUT_CYCLES - 1);
  localparam logic [31:0] C_R_LAST = 32'(RST_CYCLES - 1);

  typedef enum logic [2:0] {
    S_LOAD   = 3'd0,
    S_MRST   = 3'd1,
    S_CLR    = 3'd2,
    S_RUN    = 3'd3,
    S_SETTLE = 3'd4,
    S_SEND   = 3'd5
  } state_t;

  state_t       r_state;
  logic [3:0]   r_idx;
  logic [31:0]  r_rcnt;
  logic [31:0]  r_tcnt;
  logic [7:0]   r_status;
  logic [31:0]  r_nonce;
  logic [2:0]   r_sidx;
  logic         r_captured;
  logic [7:0]   r_block [12];
  logic [15:0]  r_target;
  logic         r_start;
  logic         r_mrst_n;
  logic [7:0]   r_out_data;
  logic         r_out_valid;
  logic [7:0]   w_next_byte;

  always_comb begin
    w_next_byte = r_nonce[7:0];
    case (r_sidx)
      3'd0:    w_next_byte = r_nonce[31:24];
      3'd1:    w_next_byte = r_nonce[23:16];
      3'd2:    w_next_byte = r_nonce[15:8];
      default: w_next_byte = r_nonce[7:0];
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_LOAD;
      r_idx       <= '0;
      r_rcnt      <= '0;
      r_tcnt      <= '0;
      r_status    <= '0;
      r_nonce     <= '0;
      r_sidx      <= '0;
      r_captured  <= 1'b0;
      for (int i = 0; i < 12; i++) r_block[i] <= '0;
      r_target    <= '0;
      r_start     <= 1'b0;
      r_mrst_n    <= 1'b0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_LOAD: begin
          if (bus.in_valid) begin
            if (r_idx < 4'd12)       r_block[r_idx]  <= bus.in_data;
            else if (r_idx == 4'd12) r_target[15:8]  <= bus.in_data;
            else                     r_target[7:0]   <= bus.in_data;
            if (r_idx == 4'd13) begin
              r_idx    <= '0;
              r_rcnt   <= '0;
              r_mrst_n <= 1'b0;
              r_start  <= 1'b0;
              r_state  <= S_MRST;
            end else begin
              r_idx <= r_idx + 4'd1;
            end
          end
        end
        S_MRST: begin
          if (r_rcnt == C_R_LAST) begin
            r_mrst_n <= 1'b1;
            r_state  <= S_CLR;
          end else begin
            r_rcnt <= r_rcnt + 32'd1;
          end
        end
        S_CLR: begin
          r_tcnt  <= '0;
          r_start <= 1'b1;
          r_state <= S_RUN;
        end
        S_RUN: begin
          r_tcnt <= r_tcnt + 32'd1;
          // finish takes priority over a coincident timeout
          if (bus.finish) begin
            r_captured <= 1'b0;
            r_state    <= S_SETTLE;
          end else if (r_tcnt == C_T_LAST) begin
            r_status    <= 8'h02;
            r_nonce     <= '0;
            r_start     <= 1'b0;
            r_sidx      <= '0;
            r_out_data  <= 8'h02;
            r_out_valid <= 1'b1;
            r_state     <= S_SEND;
          end
        end
        S_SETTLE: begin
          // first cycle lets the nonce settle and captures it, second launches the frame
          if (!r_captured) begin
            r_captured <= 1'b1;
            r_nonce    <= {bus.nonce0, bus.nonce1, bus.nonce2, bus.nonce3};
            r_status   <= 8'h01;
          end else begin
            r_captured  <= 1'b0;
            r_start     <= 1'b0;
            r_sidx      <= '0;
            r_out_data  <= r_status;
            r_out_valid <= 1'b1;
            r_state     <= S_SEND;
          end
        end
        S_SEND: begin
          if (bus.out_ready) begin
            if (r_sidx == 3'd4) begin
              r_sidx      <= '0;
              r_out_valid <= 1'b0;
              r_out_data  <= '0;
              r_state     <= S_LOAD;
            end else begin
              r_out_data <= w_next_byte;
              r_sidx     <= r_sidx + 3'd1;
            end
          end
        end
        default: r_state <= S_LOAD;
      endcase
    end
  end

  assign bus.in_ready    = (r_state == S_LOAD);
  assign bus.busy        = (r_state != S_LOAD);
  assign bus.out_data    = r_out_data;
  assign bus.out_valid   = r_out_valid;
  assign bus.start       = r_start;
  assign bus.miner_rst_n = r_mrst_n;
  assign bus.target      = r_target;
  assign bus.block0      = r_block[0];
  assign bus.block1      = r_block[1];
  assign bus.block2      = r_block[2];
  assign bus.block3      = r_block[3];
  assign bus.block4      = r_block[4];
  assign bus.block5      = r_block[5];
  assign bus.block6      = r_block[6];
  assign bus.block7      = r_block[7];
  assign bus.block8      = r_block[8];
  assign bus.block9      = r_block[9];
  assign bus.block10     = r_block[10];
  assign bus.block11     = r_block[11];

endmodule

`default_nettype wire

// File: tb/tb_miner_job_ctrl.sv
// ============================================================================
// tb_miner_job_ctrl : directed + randomized jobs against a frame/timing model
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_miner_job_ctrl;
  localparam int T = 16;
  localparam int R = 2;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;
  logic [7:0] job [14];

  miner_job_ctrl_if bus ();

  miner_job_ctrl #(.TIMEOUT_CYCLES(T), .RST_CYCLES(R)) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] blk(input int i);
    case (i)
      0: return bus.block0;   1: return bus.block1;   2: return bus.block2;
      3: return bus.block3;   4: return bus.block4;   5: return bus.block5;
      6: return bus.block6;   7: return bus.block7;   8: return bus.block8;
      9: return bus.block9;  10: return bus.block10;  default: return bus.block11;
    endcase
  endfunction

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".in_ready"}, 32'(bus.in_ready), 32'd1);
    chk({tag, ".out_valid"}, 32'(bus.out_valid), 32'd0);
    chk({tag, ".out_data"}, 32'(bus.out_data), 32'd0);
    chk({tag, ".start"}, 32'(bus.start), 32'd0);
    chk({tag, ".miner_rst_n"}, 32'(bus.miner_rst_n), 32'd0);
    chk({tag, ".busy"}, 32'(bus.busy), 32'd0);
    chk({tag, ".target"}, 32'(bus.target), 32'd0);
    for (int i = 0; i < 12; i++) chk($sformatf("%s.block%0d", tag, i), 32'(blk(i)), 32'd0);
  endtask

  task automatic do_reset(input string tag);
    bus.in_valid = 1'b0;
    bus.finish   = 1'b0;
    #1 rst = 1'b1;
    #1 chk_reset_vals({tag, "_async"});
    @(negedge clk);
    chk_reset_vals({tag, "_held"});
    rst = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    bus.in_valid = 1'b0;
    repeat (gap) @(negedge clk);
    chk("in_ready_load", 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic load_bytes(input int n, input int gap_max);
    for (int i = 0; i < n; i++) send_byte(job[i], (gap_max > 0) ? $urandom_range(gap_max, 0) : 0);
  endtask

  // Full job: fin_at = RUN cycle in which finish is raised (outside 1..T means never)
  task automatic run_job(input int fin_at, input logic [31:0] nonce, input int gap_max,
                         input int rmode, input bit junk);
    logic [7:0] frame [5];
    int exp_run, runs, got, cyc;
    bit prev_stall, rdy;
    logic [7:0] prev_data;
    bit found = (fin_at >= 1 && fin_at <= T);
    frame[0] = found ? 8'h01 : 8'h02;
    frame[1] = found ? nonce[31:24] : 8'h00;
    frame[2] = found ? nonce[23:16] : 8'h00;
    frame[3] = found ? nonce[15:8]  : 8'h00;
    frame[4] = found ? nonce[7:0]   : 8'h00;
    exp_run  = found ? fin_at + 2 : T;
    {bus.nonce0, bus.nonce1, bus.nonce2, bus.nonce3} = $urandom | 32'h1;

    load_bytes(14, gap_max);
    for (int c = 1; c <= R + 2; c++) begin
      chk($sformatf("mrst_n_c%0d", c), 32'(bus.miner_rst_n), (c <= R) ? 32'd0 : 32'd1);
      chk($sformatf("start_c%0d", c), 32'(bus.start), (c == R + 2) ? 32'd1 : 32'd0);
      chk("busy_seq", 32'(bus.busy), 32'd1);
      if (c < R + 2) @(negedge clk);
    end

    runs = 0;
    while (bus.start === 1'b1 && runs < 300) begin
      runs++;
      chk("in_ready_run", 32'(bus.in_ready), 32'd0);
      chk("out_valid_run", 32'(bus.out_valid), 32'd0);
      bus.finish = (runs == fin_at);
      if (runs == fin_at) {bus.nonce0, bus.nonce1, bus.nonce2, bus.nonce3} = nonce;
      if (junk) begin
        bus.in_valid = 1'b1;
        bus.in_data  = 8'($urandom);
      end
      @(negedge clk);
    end
    bus.finish   = 1'b0;
    bus.in_valid = 1'b0;
    chk("start_high_cycles", 32'(runs), 32'(exp_run));
    chk("out_valid_rise", 32'(bus.out_valid), 32'd1);

    got = 0;
    cyc = 0;
    prev_stall = 1'b0;
    prev_data  = '0;
    while (got < 5 && cyc < 100) begin
      chk("in_ready_send", 32'(bus.in_ready), 32'd0);
      chk("out_valid_send", 32'(bus.out_valid), 32'd1);
      if (prev_stall) chk("out_data_stall", 32'(bus.out_data), 32'(prev_data));
      case (rmode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 3 == 0);
        default: rdy = 1'($urandom);
      endcase
      bus.out_ready = rdy;
      if (bus.out_valid && rdy) begin
        chk($sformatf("frame_byte%0d", got), 32'(bus.out_data), 32'(frame[got]));
        got++;
      end
      prev_stall = bus.out_valid && !rdy;
      prev_data  = bus.out_data;
      cyc++;
      @(negedge clk);
    end
    bus.out_ready = 1'b0;
    chk("frame_len", 32'(got), 32'd5);
    if (rmode == 0) chk("frame_cycles", 32'(cyc), 32'd5);
    chk("out_valid_end", 32'(bus.out_valid), 32'd0);
    chk("in_ready_end", 32'(bus.in_ready), 32'd1);
    chk("busy_end", 32'(bus.busy), 32'd0);
    for (int i = 0; i < 12; i++) chk($sformatf("block%0d", i), 32'(blk(i)), 32'(job[i]));
    chk("target", 32'(bus.target), {16'd0, job[12], job[13]});
  endtask

  task automatic rand_job();
    for (int i = 0; i < 14; i++) job[i] = 8'($urandom);
  endtask

  initial begin
    rst = 1'b1;
    bus.in_data = '0;  bus.in_valid = 1'b0;  bus.out_ready = 1'b0;  bus.finish = 1'b0;
    {bus.nonce0, bus.nonce1, bus.nonce2, bus.nonce3} = '0;
    repeat (2) @(negedge clk);
    chk_reset_vals("por");
    rst = 1'b0;
    @(negedge clk);

    // happy path: 0x00..0x0B, target 0x000A, nonce DEADBEEF
    for (int i = 0; i < 12; i++) job[i] = 8'(i);
    job[12] = 8'h00;  job[13] = 8'h0A;
    run_job(10, 32'hDEADBEEF, 0, 0, 1'b0);
    chk("happy_block5", 32'(bus.block5), 32'h05);
    chk("happy_target", 32'(bus.target), 32'h000A);

    // timeout
    rand_job();
    run_job(0, 32'h0, 0, 0, 1'b0);

    // finish in the last RUN cycle
    rand_job();
    run_job(T, $urandom, 0, 0, 1'b0);

    // backpressure 1 on / 2 off
    rand_job();
    run_job($urandom_range(T - 1, 1), $urandom, 0, 1, 1'b0);

    // load stalls and junk bytes offered while busy
    rand_job();
    run_job($urandom_range(T, 1), $urandom, 3, 2, 1'b1);

    // reset mid-load after byte 7
    rand_job();
    load_bytes(8, 1);
    do_reset("rst_load");

    // reset mid-RUN
    rand_job();
    load_bytes(14, 0);
    repeat (R + 6) @(negedge clk);
    chk("pre_rst_start", 32'(bus.start), 32'd1);
    do_reset("rst_run");

    // clean job after resets: index must restart at 0
    rand_job();
    run_job($urandom_range(T, 1), $urandom, 0, 0, 1'b0);

    for (int k = 0; k < 6; k++) begin
      rand_job();
      run_job($urandom_range(T + 4, 1), $urandom, $urandom_range(2, 0),
              $urandom_range(2, 0), 1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
